// File: rtl/seven_seg_digit_driver.sv
// Four-digit seven-segment driver: sequential double-dabble binary-to-BCD conversion,
// registered display value, and active-low segment decode for the digit the scanner enables.
`timescale 1ns/1ps

// state | meaning
// IDLE  | waiting for load; display register holds the last result
// CONV  | double-dabble running, one adjust+shift per clk, 14 shifts total
module seven_seg_digit_driver #(
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [13:0] value,
    input  logic        load,
    input  logic [3:0]  anode,
    output logic        busy,
    output logic        done,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [3:0] LAST_STEP = 4'd13;

    typedef enum logic {
        IDLE,
        CONV
    } state_t;

    state_t      state;
    logic [13:0] shift_q;
    logic [15:0] work_q;
    logic [3:0]  count_q;
    logic        ovf_q;
    logic [15:0] disp_q;
    logic        disp_ovf_q;
    logic [3:0]  anode_meta;
    logic [3:0]  anode_sync;

    logic [15:0] work_adj;
    logic [15:0] work_next;
    logic [13:0] shift_next;

    function automatic logic [6:0] decode_digit(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // Add-3 correction on every BCD nibble, then shift {work, shift} left by one.
    always_comb begin
        work_adj = work_q;
        for (int i = 0; i < 4; i++) begin
            if (work_q[4*i +: 4] >= 4'd5) begin
                work_adj[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
            end
        end
        work_next  = {work_adj[14:0], shift_q[13]};
        shift_next = {shift_q[12:0], 1'b0};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            shift_q    <= '0;
            work_q     <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            disp_q     <= '0;
            disp_ovf_q <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (load) begin
                        shift_q <= value;
                        work_q  <= '0;
                        count_q <= '0;
                        ovf_q   <= (value > 14'd9999);
                        busy    <= 1'b1;
                        state   <= CONV;
                    end
                end
                CONV: begin
                    work_q  <= work_next;
                    shift_q <= shift_next;
                    count_q <= count_q + 4'd1;
                    if (count_q == LAST_STEP) begin
                        disp_q     <= work_next;
                        disp_ovf_q <= ovf_q;
                        done       <= 1'b1;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            anode_meta <= 4'b1111;
            anode_sync <= 4'b1111;
        end else begin
            anode_meta <= anode;
            anode_sync <= anode_meta;
        end
    end

    logic       sel_valid;
    logic [1:0] sel_idx;
    logic [3:0] sel_nib;
    logic [3:0] nib_zero;
    logic [3:0] blank_mask;

    always_comb begin
        sel_valid = 1'b1;
        sel_idx   = 2'd0;
        case (anode_sync)
            4'b1110: sel_idx = 2'd0;
            4'b1101: sel_idx = 2'd1;
            4'b1011: sel_idx = 2'd2;
            4'b0111: sel_idx = 2'd3;
            default: sel_valid = 1'b0;
        endcase
    end

    // A digit is a leading zero only if it and every more significant digit are zero.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            nib_zero[i] = (disp_q[4*i +: 4] == 4'd0);
        end
        blank_mask[0] = 1'b0;
        blank_mask[1] = BLANK_LEADING && nib_zero[3] && nib_zero[2] && nib_zero[1];
        blank_mask[2] = BLANK_LEADING && nib_zero[3] && nib_zero[2];
        blank_mask[3] = BLANK_LEADING && nib_zero[3];
    end

    always_comb begin
        sel_nib = disp_q[{sel_idx, 2'b00} +: 4];
        if (!sel_valid) begin
            seg = SEG_BLANK;
        end else if (disp_ovf_q) begin
            seg = SEG_DASH;
        end else if (blank_mask[sel_idx]) begin
            seg = SEG_BLANK;
        end else begin
            seg = decode_digit(sel_nib);
        end
    end

    assign dp = 1'b1;

endmodule

// File: tb/tb_seven_seg_digit_driver.sv
// Directed plus random checks of the seven-segment driver against a decimal-arithmetic model,
// run on two instances (leading-zero blanking on and off) sharing the same stimulus.
`timescale 1ns/1ps

module tb_seven_seg_digit_driver;

    logic        clk = 1'b0;
    logic        reset;
    logic [13:0] value;
    logic        load;
    logic [3:0]  anode;
    logic        busy1, done1, dp1;
    logic [6:0]  seg1;
    logic        busy0, done0, dp0;
    logic [6:0]  seg0;

    int checks = 0;
    int errors = 0;
    int model_val = 0;
    bit model_ovf = 1'b0;

    localparam logic [6:0] SEG_TAB [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    seven_seg_digit_driver #(.BLANK_LEADING(1'b1)) dut1 (
        .clk(clk), .reset(reset), .value(value), .load(load), .anode(anode),
        .busy(busy1), .done(done1), .seg(seg1), .dp(dp1)
    );

    seven_seg_digit_driver #(.BLANK_LEADING(1'b0)) dut0 (
        .clk(clk), .reset(reset), .value(value), .load(load), .anode(anode),
        .busy(busy0), .done(done0), .seg(seg0), .dp(dp0)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Expected segments from decimal arithmetic: digit k is (v / 10^k) % 10,
    // and it is a leading zero exactly when v < 10^k.
    function automatic logic [6:0] exp_seg(input int v, input bit ovf, input logic [3:0] an, input bit bl);
        int n = 0;
        int k = 0;
        int pw = 1;
        for (int i = 0; i < 4; i++) begin
            if (an[i] == 1'b0) begin
                n++;
                k = i;
            end
        end
        if (n != 1) return 7'b1111111;
        if (ovf) return 7'b0111111;
        for (int j = 0; j < k; j++) pw *= 10;
        if (bl && k > 0 && v < pw) return 7'b1111111;
        return SEG_TAB[(v / pw) % 10];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic show(input logic [3:0] an, input string tag);
        anode = an;
        tick();
        tick();
        chk($sformatf("%s_bl1_an%b", tag, an), {25'd0, seg1}, {25'd0, exp_seg(model_val, model_ovf, an, 1'b1)});
        chk($sformatf("%s_bl0_an%b", tag, an), {25'd0, seg0}, {25'd0, exp_seg(model_val, model_ovf, an, 1'b0)});
    endtask

    task automatic check_display(input string tag);
        for (int k = 0; k < 4; k++) begin
            show(~(4'b0001 << k), tag);
        end
    endtask

    task automatic convert(input int v, input string tag);
        int cyc = 0;
        value = v[13:0];
        load  = 1'b1;
        tick();
        load  = 1'b0;
        chk({tag, "_busy_start"}, {31'd0, busy1}, 32'd1);
        while (!done1 && cyc < 40) begin
            tick();
            cyc++;
        end
        chk({tag, "_latency"}, cyc, 32'd14);
        chk({tag, "_busy_end"}, {31'd0, busy1}, 32'd0);
        model_val = v;
        model_ovf = (v > 9999);
        tick();
        chk({tag, "_done_width"}, {31'd0, done1}, 32'd0);
        check_display(tag);
    endtask

    initial begin
        int rv;
        int cyc;
        int ndone;
        int first_done;
        int last_done;
        bit spacing_ok;

        reset = 1'b1;
        value = '0;
        load  = 1'b0;
        anode = 4'b1110;
        #12;
        chk("rst_busy", {31'd0, busy1}, 32'd0);
        chk("rst_done", {31'd0, done1}, 32'd0);
        chk("rst_seg", {25'd0, seg1}, 32'h7f);
        chk("rst_dp", {30'd0, dp1, dp0}, 32'd3);
        @(posedge clk);
        #1 reset = 1'b0;
        tick();
        tick();
        chk("idle_seg0", {25'd0, seg1}, {25'd0, 7'b1000000});
        check_display("idle");

        convert(1234, "v1234");
        convert(9999, "v9999");
        convert(10000, "v10000");
        convert(0, "v0");
        convert(7, "v7");
        convert(1007, "v1007");
        convert(16383, "v16383");
        convert(10, "v10");

        for (int i = 0; i < 8; i++) begin
            rv = (i % 4 == 3) ? int'($urandom_range(10000, 16383)) : int'($urandom_range(0, 9999));
            convert(rv, $sformatf("rand%0d", i));
        end

        // load pulse during CONV must be ignored
        value = 14'd1234;
        load  = 1'b1;
        tick();
        load  = 1'b0;
        repeat (4) tick();
        value = 14'd5678;
        load  = 1'b1;
        tick();
        load  = 1'b0;
        ndone = 0;
        first_done = -1;
        for (int c = 6; c <= 30; c++) begin
            tick();
            if (done1) begin
                ndone++;
                if (first_done < 0) first_done = c;
            end
        end
        chk("busyprot_ndone", ndone, 32'd1);
        chk("busyprot_when", first_done, 32'd14);
        model_val = 1234;
        model_ovf = 1'b0;
        check_display("busyprot");

        // continuous load: done every 15 cycles
        value = 14'd4321;
        load  = 1'b1;
        ndone = 0;
        last_done = -1;
        spacing_ok = 1'b1;
        for (int c = 1; c <= 62; c++) begin
            tick();
            if (done1) begin
                if (last_done >= 0 && c - last_done != 15) spacing_ok = 1'b0;
                last_done = c;
                ndone++;
            end
        end
        load = 1'b0;
        chk("held_ndone", ndone, 32'd4);
        chk("held_spacing", {31'd0, spacing_ok}, 32'd1);
        cyc = 0;
        while (busy1 && cyc < 40) begin
            tick();
            cyc++;
        end
        chk("held_drain", {31'd0, busy1}, 32'd0);
        model_val = 4321;
        check_display("held");

        // reset in the middle of a conversion
        value = 14'd8765;
        load  = 1'b1;
        tick();
        load  = 1'b0;
        repeat (7) tick();
        chk("midrst_busy_before", {31'd0, busy1}, 32'd1);
        reset = 1'b1;
        #1;
        chk("midrst_busy", {31'd0, busy1}, 32'd0);
        chk("midrst_done", {31'd0, done1}, 32'd0);
        chk("midrst_seg", {25'd0, seg1}, 32'h7f);
        tick();
        reset = 1'b0;
        model_val = 0;
        model_ovf = 1'b0;
        ndone = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (done1 || done0) ndone++;
        end
        chk("midrst_nodone", ndone, 32'd0);
        check_display("midrst");

        convert(56, "v56");
        show(4'b1100, "invalid");
        show(4'b1111, "invalid");
        show(4'b0000, "invalid");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
